// File: rtl/regfile_pkg.sv
// Shared widths, link register index and flat-vector slicing helper
// for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_RD_DEF   = 2;
    localparam int LINK_REG_DEF = 31;

    // Bit offset of lane k inside a flat vector of w-bit lanes.
    function automatic int port_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: write/link bypass mux and pending-result busy flag.
// Storage lookup is done by the caller; this port only resolves hazards.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              pend_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              lk_en_i,
    input  logic [DATA_W-1:0] lk_data_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);

    logic nz;
    logic hit_w;
    logic hit_l;

    assign nz    = (raddr_i != '0);
    assign hit_w = BYPASS && wr_en_i && nz && (wr_addr_i == raddr_i);
    assign hit_l = BYPASS && lk_en_i && nz &&
                   (raddr_i == ADDR_W'(LINK_REG));

    // Main write beats link write; otherwise the stored value.
    always_comb begin
        rdata_o = stored_i;
        if (hit_w)
            rdata_o = wr_data_i;
        else if (hit_l)
            rdata_o = lk_data_i;
    end

    // A result landing this cycle (when forwarded) hides the pending bit.
    assign busy_o = pend_i && !(hit_w || hit_l);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, link write port,
// optional write bypass and per-register pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] Raddr,
    output logic [NUM_RD*DATA_W-1:0] Rdata,
    output logic [NUM_RD-1:0]        Rbusy,
    input  logic                     Write,
    input  logic [ADDR_W-1:0]        Rw,
    input  logic [DATA_W-1:0]        busW,
    input  logic                     LinkWrite,
    input  logic [DATA_W-1:0]        w_Link,
    output logic [DATA_W-1:0]        r_Link,
    input  logic                     Reserve,
    input  logic [ADDR_W-1:0]        RsvAddr
);

    localparam int NREG = 2 ** ADDR_W;

    if (LINK_REG >= NREG || LINK_REG < 1) begin : g_bad_link
        $error("regfile_mp: LINK_REG out of range");
    end

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_d;

    // Next state of storage and scoreboard; register 0 never changes.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int r = 1; r < NREG; r++) begin
            if (Write && Rw == ADDR_W'(r))
                regs_d[r] = busW;
            else if (LinkWrite && r == LINK_REG)
                regs_d[r] = w_Link;

            if (Reserve && RsvAddr == ADDR_W'(r))
                pend_d[r] = 1'b1;
            else if ((Write && Rw == ADDR_W'(r)) ||
                     (LinkWrite && r == LINK_REG))
                pend_d[r] = 1'b0;
        end
    end

    // Storage and pending bits, cleared asynchronously.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int r = 0; r < NREG; r++)
                regs_q[r] <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign r_Link = regs_q[LINK_REG];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = Raddr[port_off(k, ADDR_W) +: ADDR_W];

        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .LINK_REG (LINK_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .raddr_i   (ra),
            .stored_i  (regs_q[ra]),
            .pend_i    (pend_q[ra]),
            .wr_en_i   (Write),
            .wr_addr_i (Rw),
            .wr_data_i (busW),
            .lk_en_i   (LinkWrite),
            .lk_data_i (w_Link),
            .rdata_o   (Rdata[port_off(k, DATA_W) +: DATA_W]),
            .busy_o    (Rbusy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench: 4-port bypassing instance alongside a
// 1-port non-bypassing instance sharing the same write-side inputs.
module tb_regfile_mp;

    logic         Clock;
    logic         Reset_n;
    logic [19:0]  Raddr;
    logic [127:0] Rdata;
    logic [3:0]   Rbusy;
    logic         Write;
    logic [4:0]   Rw;
    logic [31:0]  busW;
    logic         LinkWrite;
    logic [31:0]  w_Link;
    logic [31:0]  r_Link;
    logic         Reserve;
    logic [4:0]   RsvAddr;
    logic [31:0]  RdataB;
    logic         RbusyB;
    logic [31:0]  r_LinkB;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.NUM_RD(4), .BYPASS(1'b1)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Raddr(Raddr),
        .Rdata(Rdata), .Rbusy(Rbusy), .Write(Write), .Rw(Rw),
        .busW(busW), .LinkWrite(LinkWrite), .w_Link(w_Link),
        .r_Link(r_Link), .Reserve(Reserve), .RsvAddr(RsvAddr)
    );

    regfile_mp #(.NUM_RD(1), .BYPASS(1'b0)) dutb (
        .Clock(Clock), .Reset_n(Reset_n), .Raddr(Raddr[4:0]),
        .Rdata(RdataB), .Rbusy(RbusyB), .Write(Write), .Rw(Rw),
        .busW(busW), .LinkWrite(LinkWrite), .w_Link(w_Link),
        .r_Link(r_LinkB), .Reserve(Reserve), .RsvAddr(RsvAddr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic         wr;
        logic [4:0]   rw;
        logic [31:0]  busw;
        logic         lw;
        logic [31:0]  wl;
        logic         rsv;
        logic [4:0]   ra;
        logic [19:0]  raddr;
        logic [127:0] erd;
        logic [3:0]   ebusy;
        logic [31:0]  elink;
        logic [31:0]  erdb;
        logic         ebusyb;
    } vec_t;

    vec_t v [16];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        Write = 0; Rw = 0; busW = 0; LinkWrite = 0; w_Link = 0;
        Reserve = 0; RsvAddr = 0;
    endtask

    initial begin
        // p3,p2,p1,p0 packing for Raddr and Rdata
        v[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0,
                  {5'd0, 5'd31, 5'd5, 5'd5},
                  {32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF},
                  4'b0, 32'h0, 32'h0, 0};
        v[1]  = '{0, 0, 0, 0, 0, 0, 0,
                  {5'd0, 5'd31, 5'd5, 5'd5},
                  {32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF},
                  4'b0, 32'h0, 32'hDEADBEEF, 0};
        v[2]  = '{1, 5'd0, 32'h1234, 0, 0, 1, 5'd0,
                  20'h0, 128'h0, 4'b0, 32'h0, 32'h0, 0};
        v[3]  = '{0, 0, 0, 0, 0, 0, 0,
                  20'h0, 128'h0, 4'b0, 32'h0, 32'h0, 0};
        v[4]  = '{1, 5'd31, 32'hAAAA0000, 1, 32'h00400010, 0, 0,
                  {5'd0, 5'd0, 5'd31, 5'd31},
                  {32'h0, 32'h0, 32'hAAAA0000, 32'hAAAA0000},
                  4'b0, 32'h0, 32'h0, 0};
        v[5]  = '{0, 0, 0, 0, 0, 0, 0,
                  {5'd0, 5'd0, 5'd31, 5'd31},
                  {32'h0, 32'h0, 32'hAAAA0000, 32'hAAAA0000},
                  4'b0, 32'hAAAA0000, 32'hAAAA0000, 0};
        v[6]  = '{0, 0, 0, 1, 32'h00400010, 0, 0,
                  {5'd0, 5'd0, 5'd31, 5'd31},
                  {32'h0, 32'h0, 32'h00400010, 32'h00400010},
                  4'b0, 32'hAAAA0000, 32'hAAAA0000, 0};
        v[7]  = '{0, 0, 0, 0, 0, 0, 0,
                  {5'd0, 5'd0, 5'd31, 5'd31},
                  {32'h0, 32'h0, 32'h00400010, 32'h00400010},
                  4'b0, 32'h00400010, 32'h00400010, 0};
        v[8]  = '{0, 0, 0, 0, 0, 1, 5'd7,
                  {5'd0, 5'd0, 5'd7, 5'd7}, 128'h0,
                  4'b0, 32'h00400010, 32'h0, 0};
        v[9]  = '{0, 0, 0, 0, 0, 0, 0,
                  {5'd0, 5'd0, 5'd7, 5'd7}, 128'h0,
                  4'b0011, 32'h00400010, 32'h0, 1};
        v[10] = '{1, 5'd7, 32'h77, 0, 0, 0, 0,
                  {5'd0, 5'd0, 5'd7, 5'd7},
                  {32'h0, 32'h0, 32'h77, 32'h77},
                  4'b0, 32'h00400010, 32'h0, 1};
        v[11] = '{0, 0, 0, 0, 0, 0, 0,
                  {5'd0, 5'd0, 5'd7, 5'd7},
                  {32'h0, 32'h0, 32'h77, 32'h77},
                  4'b0, 32'h00400010, 32'h77, 0};
        v[12] = '{1, 5'd7, 32'h88, 0, 0, 1, 5'd7,
                  {5'd0, 5'd0, 5'd7, 5'd7},
                  {32'h0, 32'h0, 32'h88, 32'h88},
                  4'b0, 32'h00400010, 32'h77, 0};
        v[13] = '{0, 0, 0, 0, 0, 0, 0,
                  {5'd0, 5'd0, 5'd7, 5'd7},
                  {32'h0, 32'h0, 32'h88, 32'h88},
                  4'b0011, 32'h00400010, 32'h88, 1};
        v[14] = '{1, 5'd3, 32'h11, 1, 32'h22, 0, 0,
                  {5'd0, 5'd31, 5'd3, 5'd3},
                  {32'h0, 32'h22, 32'h11, 32'h11},
                  4'b0, 32'h00400010, 32'h0, 0};
        v[15] = '{0, 0, 0, 0, 0, 0, 0,
                  {5'd0, 5'd31, 5'd3, 5'd3},
                  {32'h0, 32'h22, 32'h11, 32'h11},
                  4'b0, 32'h22, 32'h11, 0};

        Reset_n = 0;
        Raddr = {5'd0, 5'd31, 5'd7, 5'd1};
        idle();
        @(posedge Clock);
        @(negedge Clock);
        #1;
        chk("rst_rdata", Rdata, 128'h0);
        chk("rst_busy", Rbusy, 128'h0);
        chk("rst_rlink", r_Link, 128'h0);
        Reset_n = 1;

        for (int i = 0; i < 16; i++) begin
            @(negedge Clock);
            Write = v[i].wr; Rw = v[i].rw; busW = v[i].busw;
            LinkWrite = v[i].lw; w_Link = v[i].wl;
            Reserve = v[i].rsv; RsvAddr = v[i].ra;
            Raddr = v[i].raddr;
            #1;
            chk($sformatf("v%0d_rdata", i), Rdata, v[i].erd);
            chk($sformatf("v%0d_busy", i), Rbusy, v[i].ebusy);
            chk($sformatf("v%0d_rlink", i), r_Link, v[i].elink);
            chk($sformatf("v%0d_rdatab", i), RdataB, v[i].erdb);
            chk($sformatf("v%0d_busyb", i), RbusyB, v[i].ebusyb);
        end

        // Reset mid-burst: pending writes/reserves must be discarded.
        @(negedge Clock);
        Write = 1; Rw = 5'd9; busW = 32'h99;
        LinkWrite = 1; w_Link = 32'h55;
        Reserve = 1; RsvAddr = 5'd10;
        #2;
        Reset_n = 0;
        #1;
        chk("async_rlink", r_Link, 128'h0);
        chk("async_rlinkb", r_LinkB, 128'h0);
        @(posedge Clock);
        @(negedge Clock);
        idle();
        Reset_n = 1;
        for (int r = 1; r < 32; r++) begin
            Raddr = {5'd0, 5'd0, 5'd0, 5'(r)};
            #1;
            chk($sformatf("post_rst_r%0d", r), Rdata[31:0], 128'h0);
            chk($sformatf("post_rst_busy%0d", r), Rbusy[0], 128'h0);
            @(negedge Clock);
        end
        chk("post_rst_rlink", r_Link, 128'h0);

        // Reserve on r0 must never show busy.
        Reserve = 1; RsvAddr = 5'd0; Raddr = 20'h0;
        @(negedge Clock);
        idle();
        #1;
        chk("r0_busy", Rbusy, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with a zero register and a dedicated link-register write port for call/return.
- Optional write-to-read bypass, plus a per-register pending (scoreboard) bit so the datapath can stall on results not yet written back.
- Sits in the CPU decode stage and replaces the fixed 2-read, 32x32 register file.
- Write-back and link (jal/jr) writes arrive from the write-back stage.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; register count NREG = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- LINK_REG, 31, index of the link register written by the link port.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return the stored value only.

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Raddr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- Rdata  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- Rbusy  out  NUM_RD  port k's register has a pending result.
- Write  in  1  main write enable.
- Rw  in  ADDR_W  main write address.
- busW  in  DATA_W  main write data.
- LinkWrite  in  1  link-register write enable.
- w_Link  in  DATA_W  link write data.
- r_Link  out  DATA_W  current stored value of LINK_REG (no bypass).
- Reserve  in  1  set the pending bit of RsvAddr.
- RsvAddr  in  ADDR_W  register to reserve.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - All registers 1..NREG-1 clear to 0; all pending bits clear to 0.
  - Consequently Rdata=0, Rbusy=0, r_Link=0 while reset is asserted and after release.
  - Reset applied mid-operation discards any same-cycle write or reserve.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes, link writes and reserves to address 0 are ignored (only relevant if LINK_REG=0, which is not a supported setting).
- Storage updates on the rising Clock edge only:
  - Write=1 and Rw!=0: reg[Rw] <= busW.
  - LinkWrite=1: reg[LINK_REG] <= w_Link.
  - Both targeting LINK_REG in the same cycle: main write wins; reg[LINK_REG] = busW.
- Reads are combinational, zero latency:
  - BYPASS=0: Rdata_k = reg[Raddr_k].
  - BYPASS=1: Rdata_k takes the first match in this order:
    - busW, if Write and Rw==Raddr_k != 0;
    - else w_Link, if LinkWrite and Raddr_k==LINK_REG;
    - else reg[Raddr_k].
  - All read ports are independent. Several ports may read the same address.
- r_Link always reflects the stored reg[LINK_REG] and is never bypassed.
- Scoreboard, evaluated per register r != 0 at each clock edge:
  - Reserve and RsvAddr==r: pending[r] <= 1. Reserve wins over a same-cycle clear.
  - Else, main write to r, or link write with r==LINK_REG: pending[r] <= 0.
  - Else pending[r] holds.
  - Rbusy_k = pending[Raddr_k] && !(BYPASS && a write to Raddr_k occurs this cycle).
  - A same-cycle Reserve does not affect Rbusy until the next cycle.
- Widths:
  - No arithmetic is performed on the data path.
  - Address comparisons use the full ADDR_W.
  - LINK_REG must be < NREG; violating this is an elaboration error.

Decomposition:
- Shared package regfile_pkg holds:
  - the default widths;
  - the LINK_REG constant (31);
  - the function that slices a flat port vector (port index -> bit offset).
- One sub-module, regfile_rdport: a single read port's bypass mux and busy logic, instantiated NUM_RD times in a generate loop.
- Storage and the scoreboard stay in the top module.

Test Plan:
- Reset: assert Reset_n=0 mid-burst of writes, release; read r1..r31 -> all 0, all Rbusy=0, r_Link=0.
- Write/read with BYPASS=1: Write=1, Rw=5, busW=0xDEADBEEF, Raddr0=5 in the same cycle -> Rdata0=0xDEADBEEF immediately. With BYPASS=0 the same cycle reads 0; the next cycle reads 0xDEADBEEF.
- Zero register: Write Rw=0, busW=0x1234 -> Rdata for address 0 stays 0 and Rbusy stays 0. Reserve RsvAddr=0 -> still not busy.
- Link collision: Write Rw=31, busW=0xAAAA0000 plus LinkWrite, w_Link=0x00400010 in the same cycle -> r_Link=0xAAAA0000 next cycle. LinkWrite alone -> r_Link=0x00400010.
- Scoreboard:
  - Reserve r7 -> next cycle Rbusy for Raddr=7 is 1.
  - Later Write Rw=7 -> Rbusy=0 in that cycle (BYPASS=1), and the pending bit clears.
  - Reserve r7 and Write r7 in the same cycle -> r7 remains busy.
- Multi-port (NUM_RD=4): four ports read 3, 3, 31, 0 with reg3=0x11 and reg31=0x22 -> Rdata = 0x11, 0x11, 0x22, 0.
